upc_serial_tx: RTL and testbench

Serial transmitter for 4-bit UPC item codes ({U,P,C,M}). It accepts a code over a valid/ready handshake and shifts it out on a single line as a framed, parity-protected bit stream. Each bit is held for a programmable number of clocks. It is the sending end of the UPC link that feeds the UPC feature-detection logic on the DE1-SoC, replacing direct switch wiring with a one-wire serial path.

---
 rtl/upc_serial_tx.sv | 170 +++++++++++++++++
 tb/tb_upc_serial_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/upc_serial_tx.sv
// upc_serial_tx
// Sends 4-bit UPC item codes {U,P,C,M} over one wire as a 7-bit frame:
// start(0), code[3], code[2], code[1], code[0], even parity, stop(1).
// Each frame bit is held on tx_line for BIT_CYCLES clocks.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   in_valid  in_code is offered for transmission
//   in_code   code to send: [3]=U, [2]=P, [1]=C, [0]=M
//   in_ready  high only while idle; a handshake is in_valid & in_ready at an edge
//   tx_line   serial output, idles high
//   busy      a frame is in progress
//   done      one-cycle pulse on the last clock of a frame
//
// State table:
//   state  | meaning
//   IDLE   | line high, waiting for a handshake
//   START  | start bit (0)
//   DATA   | code bits, MSB first, bit index counts 3 down to 0
//   PARITY | even parity bit (^code)
//   STOP   | stop bit (1); done marks its final clock

module upc_serial_tx #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic       in_ready,
  output logic       tx_line,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Terminal count of the per-bit cycle counter.
  localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        // in_ready is high exactly in IDLE, so in_valid alone completes
        // the handshake here.
        if (in_valid) begin
          shreg_d = in_code;
          par_d   = ^in_code;
          idx_d   = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          idx_d   = 2'd3;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (idx_q == 2'd0) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next-state values and registered, so every
  // output is a flop and in_valid/in_code never reach a pin combinationally.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[idx_d];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && (cnt_d == BIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      shreg_q <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_line  = tx_q;
  assign busy     = busy_q;
  assign in_ready = ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_upc_serial_tx.sv
module tb_upc_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v4, v1, v2;
  logic [3:0] c4, c1, c2;
  logic       r4, t4, b4, d4;
  logic       r1, t1, b1, d1;
  logic       r2, t2, b2, d2;

  int checks = 0;
  int failures = 0;

  upc_serial_tx #(.BIT_CYCLES(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_code(c4),
    .in_ready(r4), .tx_line(t4), .busy(b4), .done(d4)
  );
  upc_serial_tx #(.BIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_code(c1),
    .in_ready(r1), .tx_line(t1), .busy(b1), .done(d1)
  );
  upc_serial_tx #(.BIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_code(c2),
    .in_ready(r2), .tx_line(t2), .busy(b2), .done(d2)
  );

  // Observed outputs packed as {tx_line, done, busy, in_ready}.
  function automatic logic [3:0] pack(int d);
    case (d)
      4:       return {t4, d4, b4, r4};
      1:       return {t1, d1, b1, r1};
      default: return {t2, d2, b2, r2};
    endcase
  endfunction

  task automatic drive(int d, logic v, logic [3:0] c);
    case (d)
      4:       begin v4 = v; c4 = c; end
      1:       begin v1 = v; c1 = c; end
      default: begin v2 = v; c2 = c; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Entered in the first cycle after the handshake edge. Checks every clock
  // of the frame against fr (fr[6] is the start bit), then the idle cycle
  // that follows. poke_k > 0 pulses in_valid with code 0011 at that clock.
  task automatic run_frame(int d, logic [6:0] fr, int bc, string tag, int poke_k);
    for (int k = 1; k <= 7 * bc; k++) begin
      logic [3:0] e;
      e = {fr[6 - (k - 1) / bc], (k == 7 * bc), 1'b1, 1'b0};
      chk($sformatf("%s_c%0d", tag, k), pack(d), e);
      if (poke_k > 0 && k == poke_k) drive(d, 1'b1, 4'b0011);
      else if (poke_k > 0 && k == poke_k + 1) drive(d, 1'b0, 4'b0011);
      step();
    end
    chk({tag, "_idle"}, pack(d), 4'b1001);
  endtask

  task automatic send(int d, logic [3:0] c);
    drive(d, 1'b1, c);
    step();
    drive(d, 1'b0, c);
  endtask

  initial begin
    // Reset held two cycles with in_valid high on every instance.
    reset = 1'b1;
    v4 = 1'b1; c4 = 4'b1010;
    v1 = 1'b1; c1 = 4'b1111;
    v2 = 1'b1; c2 = 4'b0001;
    step();
    chk("rst_c1", pack(4), 4'b1001);
    step();
    chk("rst_c2", pack(4), 4'b1001);
    reset = 1'b0;
    v4 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    step();
    chk("rst_rel4", pack(4), 4'b1001);
    chk("rst_rel1", pack(1), 4'b1001);
    chk("rst_rel2", pack(2), 4'b1001);

    // Single frame, BIT_CYCLES=4, code 1010.
    send(4, 4'b1010);
    run_frame(4, 7'b0101001, 4, "f1010", 0);

    // Parity, BIT_CYCLES=1.
    send(1, 4'b0000);
    run_frame(1, 7'b0000001, 1, "p0000", 0);
    send(1, 4'b0111);
    run_frame(1, 7'b0011111, 1, "p0111", 0);
    send(1, 4'b1111);
    run_frame(1, 7'b0111101, 1, "p1111", 0);

    // Input while busy is ignored; nothing starts afterwards without a handshake.
    send(4, 4'b1100);
    run_frame(4, 7'b0110001, 4, "busy1100", 10);
    step();
    chk("busy_after1", pack(4), 4'b1001);
    step();
    chk("busy_after2", pack(4), 4'b1001);

    // Back-to-back, BIT_CYCLES=2, in_valid held high throughout the first frame.
    drive(2, 1'b1, 4'b0001);
    step();
    drive(2, 1'b1, 4'b1000);
    run_frame(2, 7'b0000111, 2, "b2b_a", 0);
    step();
    drive(2, 1'b0, 4'b1000);
    run_frame(2, 7'b0100011, 2, "b2b_b", 0);

    // Reset during DATA bit 2 of code 1111, with a handshake offered at the same edge.
    send(4, 4'b1111);
    for (int k = 1; k <= 9; k++) begin
      logic [6:0] fr;
      fr = 7'b0111101;
      chk($sformatf("abort_c%0d", k), pack(4), {fr[6 - (k - 1) / 4], 1'b0, 1'b1, 1'b0});
      if (k < 9) step();
    end
    reset = 1'b1;
    drive(4, 1'b1, 4'b0101);
    step();
    chk("abort_rst", pack(4), 4'b1001);
    reset = 1'b0;
    drive(4, 1'b0, 4'b0101);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("abort_idle%0d", k), pack(4), 4'b1001);
    end
    send(4, 4'b0101);
    run_frame(4, 7'b0010101, 4, "after0101", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
